// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch/prefetch stage: reads the synchronous program ROM,
// buffers fetched words with their pc in a small queue and hands them to
// the core over valid/ready. A redirect flushes buffered and in-flight
// fetches and restarts fetching at the new address.
module fetch_prefetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  entry_t                q_mem [DEPTH];
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;

  logic                  pop_c;
  logic                  push_c;
  logic [OW-1:0]         occ_c;
  logic [OW-1:0]         lim_c;

  // Credit check: issue a read only if its response is guaranteed a slot.
  always_comb begin
    pop_c  = instr_valid && instr_ready;
    push_c = inflight_q && !redirect;
    occ_c  = OW'(count_q) + OW'(inflight_q);
    lim_c  = OW'(DEPTH) + OW'(pop_c);
    rom_en = !redirect && (occ_c < lim_c);
  end

  assign rom_addr    = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = q_mem[rd_ptr_q].word;
  assign instr_pc    = q_mem[rd_ptr_q].pc;

  // Fetch pointer, in-flight tracking and queue update; redirect wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_mem[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_pc_q    <= RESET_PC;
    end else if (redirect) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      fetch_pc_q <= redirect_pc;
    end else begin
      if (rom_en) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + ADDR_WIDTH'(1);
      end else begin
        inflight_q    <= 1'b0;
      end
      if (push_c) begin
        q_mem[wr_ptr_q] <= '{word: rom_data, pc: inflight_pc_q};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_c) - CW'(pop_c);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed cycle table plus reset and random-scoreboard sequences for the
// fetch/prefetch unit, against a behavioural synchronous ROM model.
module tb_fetch_prefetch_unit;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned NV    = 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  fetch_prefetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(12'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: ROM[n] = n ^ 0xA5A5; junk when not read.
  always @(posedge clk) begin
    if (rom_en) rom_data <= DW'(rom_addr) ^ 16'hA5A5;
    else        rom_data <= 16'hDEAD;
  end

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return DW'(a) ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Queue must never receive a push while full.
  task automatic overflow_check();
    if (rst_n && !redirect && dut.inflight_q && (int'(dut.count_q) >= int'(DEPTH))) begin
      total++;
      bad++;
      $display("FAIL overflow push into full queue t=%0t", $time);
    end
  endtask

  typedef struct {
    logic          rdy;
    logic          redir;
    logic [AW-1:0] rpc;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic          e_valid;
    logic [AW-1:0] e_pc;
  } vec_t;

  vec_t vt [NV];

  logic [AW-1:0] exp_pc;
  int            idle;

  initial begin
    // cycle-by-cycle from reset release: {rdy, redir, rpc, en, addr, valid, pc}
    vt[0]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 12'h000};
    vt[1]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 1'b0, 12'h000};
    vt[2]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h000};
    vt[3]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h000};
    vt[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h000};
    vt[5]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h000};
    vt[6]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h000};
    vt[7]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b1, 12'h000};
    vt[8]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h003, 1'b1, 12'h001};
    vt[9]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h004, 1'b1, 12'h002};
    vt[10] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h003};
    vt[11] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h003};
    vt[12] = '{1'b1, 1'b1, 12'h123, 1'b0, 12'h000, 1'b1, 12'h003};
    vt[13] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h123, 1'b0, 12'h000};
    vt[14] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h124, 1'b0, 12'h000};
    vt[15] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h125, 1'b1, 12'h123};
    vt[16] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h126, 1'b1, 12'h124};
    vt[17] = '{1'b1, 1'b1, 12'hFFE, 1'b0, 12'h000, 1'b1, 12'h125};
    vt[18] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'hFFE, 1'b0, 12'h000};
    vt[19] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'hFFF, 1'b0, 12'h000};
    vt[20] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b1, 12'hFFE};
    vt[21] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 1'b1, 12'hFFF};
    vt[22] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b1, 12'h000};
    vt[23] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h003, 1'b1, 12'h001};
    vt[24] = '{1'b1, 1'b1, 12'h050, 1'b0, 12'h000, 1'b1, 12'h002};
    vt[25] = '{1'b1, 1'b1, 12'h070, 1'b0, 12'h000, 1'b0, 12'h000};
    vt[26] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h070, 1'b0, 12'h000};
    vt[27] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h071, 1'b0, 12'h000};
    vt[28] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h072, 1'b1, 12'h070};
    vt[29] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h073, 1'b1, 12'h071};

    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr", 32'(instr), 32'd0);
    chk("reset_pc",    32'(instr_pc), 32'd0);

    // Directed table: streaming, stall, redirect, wrap, back-to-back redirect.
    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      instr_ready = vt[i].rdy;
      redirect    = vt[i].redir;
      redirect_pc = vt[i].rpc;
      #1;
      overflow_check();
      chk($sformatf("v%0d_rom_en", i), 32'(rom_en), 32'(vt[i].e_en));
      if (vt[i].e_en) chk($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), 32'(instr_pc), 32'(vt[i].e_pc));
        chk($sformatf("v%0d_instr", i), 32'(instr), 32'(rom_word(vt[i].e_pc)));
      end
    end

    // Async reset mid-stream with a read in flight.
    @(negedge clk);
    instr_ready = 1'b1;
    redirect    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_instr", 32'(instr), 32'd0);
    chk("async_pc",    32'(instr_pc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_c0_en",    32'(rom_en), 32'd1);
    chk("rel_c0_addr",  32'(rom_addr), 32'h000);
    chk("rel_c0_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rel_c1_addr",  32'(rom_addr), 32'h001);
    chk("rel_c1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rel_c2_valid", 32'(instr_valid), 32'd1);
    chk("rel_c2_pc",    32'(instr_pc), 32'h000);
    chk("rel_c2_instr", 32'(instr), 32'(rom_word(12'h000)));

    // Random ready/redirect against an in-order pc scoreboard.
    exp_pc = '0;
    idle   = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = (c == 0) || ($urandom_range(0, 99) < 3);
      redirect_pc = AW'($urandom);
      #1;
      overflow_check();
      if (instr_valid && instr_ready && !redirect) begin
        chk("rnd_pc", 32'(instr_pc), 32'(exp_pc));
        chk("rnd_instr", 32'(instr), 32'(rom_word(exp_pc)));
        exp_pc = exp_pc + AW'(1);
      end
      if (redirect) begin
        exp_pc = redirect_pc;
        idle   = 0;
      end else if (!instr_valid) begin
        idle++;
        if (idle > 3) begin
          total++;
          bad++;
          $display("FAIL rnd_starve idle=%0d want<=3 t=%0t", idle, $time);
          idle = 0;
        end
      end else begin
        idle = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
